// File: rtl/m68k_bus_ctrl_if.sv
// 68000 CPU-side bus bundle: strobes and address in, DTACK/BERR back to the CPU.
interface m68k_bus_ctrl_if;
    logic        as_n;
    logic        uds_n;
    logic        lds_n;
    logic        rw;
    logic [10:0] addr;
    logic        dtack_n;
    logic        dtack_oe;
    logic        berr_n;

    // CPU side drives the cycle, sees the acknowledge
    modport master (
        output as_n, uds_n, lds_n, rw, addr,
        input  dtack_n, dtack_oe, berr_n
    );

    // Bus controller side
    modport slave (
        input  as_n, uds_n, lds_n, rw, addr,
        output dtack_n, dtack_oe, berr_n
    );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// 68000 bus controller: address decode, boot ROM overlay, DTACK wait states,
// IO acknowledge forwarding, BERR on unmapped/timeout, divided clock output.
module m68k_bus_ctrl #(
    parameter int unsigned ROM_BASE  = 32'h10_0000,
    parameter int unsigned ROM_SIZE  = 32'h4000,
    parameter int unsigned RAM_TOP   = 32'h10_0000,
    parameter int unsigned IO_BASE   = 32'hF0_0000,
    parameter int unsigned IO_SIZE   = 32'h10_0000,
    parameter int unsigned ROM_WAIT  = 4,
    parameter int unsigned RAM_WAIT  = 0,
    parameter int unsigned TO_CYCLES = 64,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    m68k_bus_ctrl_if.slave        bus,
    input  logic                  boot,
    input  logic                  dtack_trig,
    input  logic                  io_dtack_n,
    output logic                  oe_n,
    output logic                  ram_ce_n,
    output logic                  rom_uds_n,
    output logic                  rom_lds_n,
    output logic                  io_cs_n,
    output logic [1:0]            cs,
    output logic                  overlay,
    output logic                  timeout_seen,
    output logic                  clk_out
);

    localparam int unsigned AW = 24;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = 8;

    localparam logic [1:0] CS_NONE = 2'd0;
    localparam logic [1:0] CS_ROM  = 2'd1;
    localparam logic [1:0] CS_RAM  = 2'd2;
    localparam logic [1:0] CS_IO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_IOWAIT,
        S_DTACK,
        S_BERR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic            manual_q, manual_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            overlay_q, overlay_d;
    logic            timeout_seen_q, timeout_seen_d;
    logic [2:0]      trig_q, trig_d;
    logic [CLK_DIV-1:0] div_q, div_d;

    logic [AW-1:0]   addr_full_c;
    logic            ds_c;
    logic            low_win_c;
    logic            trig_edge_c;
    logic            to_hit_c;
    logic            to_fire_c;
    logic            ovl_clr_c;

    assign addr_full_c = {bus.addr, 13'd0};
    assign ds_c        = ~bus.uds_n | ~bus.lds_n;
    assign low_win_c   = (32'(addr_full_c) < ROM_SIZE);
    assign trig_edge_c = trig_q[1] & ~trig_q[2];
    assign to_hit_c    = (to_cnt_q == TW'(TO_CYCLES));

    // Address decode with overlay/boot priority; idle bus selects nothing
    always_comb begin
        cs = CS_NONE;
        if (!bus.as_n) begin
            if (low_win_c && ((overlay_q && bus.rw) || boot)) begin
                cs = CS_ROM;
            end else if (32'(addr_full_c) < RAM_TOP) begin
                cs = CS_RAM;
            end else if ((32'(addr_full_c) >= ROM_BASE) &&
                         (32'(addr_full_c) < ROM_BASE + ROM_SIZE)) begin
                cs = CS_ROM;
            end else if ((32'(addr_full_c) >= IO_BASE) &&
                         (32'(addr_full_c) < IO_BASE + IO_SIZE)) begin
                cs = CS_IO;
            end
        end
    end

    // Memory/IO strobes derived from the decode
    always_comb begin
        oe_n      = boot ? 1'b1 : ~bus.rw;
        ram_ce_n  = ~((cs == CS_RAM) && ds_c);
        rom_uds_n = (cs == CS_ROM) ? bus.uds_n : 1'b1;
        rom_lds_n = (cs == CS_ROM) ? bus.lds_n : 1'b1;
        io_cs_n   = ~(cs == CS_IO);
    end

    // First write into the low window outside boot mode drops the ROM overlay
    assign ovl_clr_c = ~bus.as_n & ds_c & ~bus.rw & low_win_c & ~boot & overlay_q;

    // Bus-cycle FSM: next state, wait counter, manual-trigger flag
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        manual_d  = manual_q;
        to_fire_c = 1'b0;
        if (bus.as_n) begin
            state_d  = S_IDLE;
            manual_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ds_c) begin
                        manual_d = 1'b0;
                        case (cs)
                            CS_NONE: state_d = S_BERR;
                            CS_ROM: begin
                                if (boot) begin
                                    state_d  = S_WAIT;
                                    manual_d = 1'b1;
                                end else if (ROM_WAIT == 0) begin
                                    state_d = S_DTACK;
                                end else begin
                                    state_d = S_WAIT;
                                    wcnt_d  = CW'(ROM_WAIT);
                                end
                            end
                            CS_RAM: begin
                                if (RAM_WAIT == 0) begin
                                    state_d = S_DTACK;
                                end else begin
                                    state_d = S_WAIT;
                                    wcnt_d  = CW'(RAM_WAIT);
                                end
                            end
                            default: state_d = S_IOWAIT;
                        endcase
                    end
                end
                S_WAIT: begin
                    if (manual_q) begin
                        if (trig_edge_c) begin
                            state_d = S_DTACK;
                        end
                    end else if (to_hit_c) begin
                        state_d   = S_BERR;
                        to_fire_c = 1'b1;
                    end else if (wcnt_q == CW'(1)) begin
                        state_d = S_DTACK;
                    end else begin
                        wcnt_d = wcnt_q - CW'(1);
                    end
                end
                S_IOWAIT: begin
                    if (to_hit_c) begin
                        state_d   = S_BERR;
                        to_fire_c = 1'b1;
                    end else if (!io_dtack_n) begin
                        state_d = S_DTACK;
                    end
                end
                S_DTACK: begin
                    if (!ds_c) begin
                        state_d = S_IDLE;
                    end
                end
                S_BERR:  state_d = S_BERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Housekeeping next state: timeout counter, sticky flags, trigger sync, divider
    always_comb begin
        to_cnt_d       = to_cnt_q;
        overlay_d      = overlay_q;
        timeout_seen_d = timeout_seen_q | to_fire_c;
        trig_d         = {trig_q[1:0], dtack_trig};
        div_d          = div_q + CLK_DIV'(1);
        if (bus.as_n) begin
            to_cnt_d = '0;
        end else if (!to_hit_c) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
        if (ovl_clr_c) begin
            overlay_d = 1'b0;
        end
    end

    // State and register update with synchronous active-low reset
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            wcnt_q         <= '0;
            manual_q       <= 1'b0;
            to_cnt_q       <= '0;
            overlay_q      <= 1'b1;
            timeout_seen_q <= 1'b0;
            trig_q         <= '0;
            div_q          <= '0;
        end else begin
            state_q        <= state_d;
            wcnt_q         <= wcnt_d;
            manual_q       <= manual_d;
            to_cnt_q       <= to_cnt_d;
            overlay_q      <= overlay_d;
            timeout_seen_q <= timeout_seen_d;
            trig_q         <= trig_d;
            div_q          <= div_d;
        end
    end

    assign bus.dtack_oe = (state_q != S_IDLE);
    assign bus.dtack_n  = ~((state_q == S_DTACK) && ds_c);
    assign bus.berr_n   = ~(state_q == S_BERR);
    assign overlay      = overlay_q;
    assign timeout_seen = timeout_seen_q;
    assign clk_out      = div_q[CLK_DIV-1];

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: directed scenarios plus randomized cycles against a decode/latency model.
module tb_m68k_bus_ctrl;

    localparam int unsigned ROM_BASE  = 32'h10_0000;
    localparam int unsigned ROM_SIZE  = 32'h4000;
    localparam int unsigned RAM_TOP   = 32'h10_0000;
    localparam int unsigned IO_BASE   = 32'hF0_0000;
    localparam int unsigned IO_SIZE   = 32'h10_0000;
    localparam int          ROM_WAIT  = 4;
    localparam int          RAM_WAIT  = 0;
    localparam int          TO_CYCLES = 64;
    localparam int          CLK_DIV   = 4;

    logic clk16 = 1'b0;
    logic reset_n;
    logic boot, dtack_trig, io_dtack_n;
    logic oe_n, ram_ce_n, rom_uds_n, rom_lds_n, io_cs_n;
    logic [1:0] cs;
    logic overlay, timeout_seen, clk_out;

    int errors = 0;
    int checks = 0;
    logic model_ovl;

    // Values observed by run_cycle
    logic [1:0] obs_cs;
    logic obs_oe_n, obs_ram_ce_n, obs_rom_u, obs_rom_l, obs_io_cs_n;
    logic obs_ovl_start, obs_berr, obs_busy_oe, obs_berr_held;
    logic obs_dtack_rel, obs_oe_idle, obs_berr_idle;
    int   obs_lat;

    m68k_bus_ctrl_if bus ();

    m68k_bus_ctrl #(
        .ROM_BASE(ROM_BASE), .ROM_SIZE(ROM_SIZE), .RAM_TOP(RAM_TOP),
        .IO_BASE(IO_BASE), .IO_SIZE(IO_SIZE),
        .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT),
        .TO_CYCLES(TO_CYCLES), .CLK_DIV(CLK_DIV)
    ) dut (
        .clk16(clk16), .reset_n(reset_n), .bus(bus),
        .boot(boot), .dtack_trig(dtack_trig), .io_dtack_n(io_dtack_n),
        .oe_n(oe_n), .ram_ce_n(ram_ce_n), .rom_uds_n(rom_uds_n), .rom_lds_n(rom_lds_n),
        .io_cs_n(io_cs_n), .cs(cs), .overlay(overlay), .timeout_seen(timeout_seen),
        .clk_out(clk_out)
    );

    always #5 clk16 = ~clk16;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference decode straight from the region rules
    function automatic logic [1:0] ref_cs(input logic [10:0] ad, input logic rd,
                                          input logic bt, input logic ovl);
        int unsigned x;
        x = int'(ad) * 32'h2000;
        if (x < ROM_SIZE && ((ovl && rd) || bt)) return 2'd1;
        if (x < RAM_TOP) return 2'd2;
        if (x >= ROM_BASE && x < ROM_BASE + ROM_SIZE) return 2'd1;
        if (x >= IO_BASE && x < IO_BASE + IO_SIZE) return 2'd3;
        return 2'd0;
    endfunction

    // Edges after the start edge until DTACK/BERR; io ack d edges after start
    function automatic int ref_lat(input logic [1:0] c, input int d);
        case (c)
            2'd1:    return ROM_WAIT;
            2'd2:    return RAM_WAIT;
            2'd3:    return (d >= 0 && d + 1 < TO_CYCLES) ? d + 1 : TO_CYCLES;
            default: return 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk16);
        #1;
    endtask

    task automatic idle_bus();
        bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
        bus.rw = 1'b1; bus.addr = '0; io_dtack_n = 1'b1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; boot = 1'b0; dtack_trig = 1'b0;
        idle_bus();
        step(); step();
        reset_n = 1'b1;
        model_ovl = 1'b1;
    endtask

    // Run one CPU cycle and record what the controller did
    task automatic run_cycle(input logic [10:0] ad, input logic rd, input logic u,
                             input logic l, input int io_delay, input int max_edges);
        bus.addr = ad; bus.rw = rd; bus.uds_n = u; bus.lds_n = l; bus.as_n = 1'b0;
        #1;
        obs_cs = cs; obs_oe_n = oe_n; obs_ram_ce_n = ram_ce_n;
        obs_rom_u = rom_uds_n; obs_rom_l = rom_lds_n; obs_io_cs_n = io_cs_n;
        obs_lat = -1; obs_berr = 1'b0; obs_busy_oe = 1'b0; obs_ovl_start = overlay;
        for (int n = 1; n <= max_edges; n++) begin
            step();
            if (n == 1) obs_ovl_start = overlay;
            if (!bus.dtack_n || !bus.berr_n) begin
                obs_lat = n - 1; obs_berr = ~bus.berr_n; obs_busy_oe = bus.dtack_oe;
                break;
            end
            if (io_delay >= 0 && n == io_delay + 1) io_dtack_n = 1'b0;
        end
        obs_berr_held = 1'b0;
        if (obs_berr) begin
            step();
            obs_berr_held = ~bus.berr_n;
        end
        bus.uds_n = 1'b1; bus.lds_n = 1'b1;
        #1;
        obs_dtack_rel = bus.dtack_n;
        io_dtack_n = 1'b1; bus.as_n = 1'b1;
        step();
        obs_oe_idle = bus.dtack_oe; obs_berr_idle = bus.berr_n;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.dtack_oe !== 1'b0) begin errors++; $display("FAIL reset_dtack_oe: got %b expected 0", bus.dtack_oe); end
        checks++; if (bus.dtack_n !== 1'b1) begin errors++; $display("FAIL reset_dtack_n: got %b expected 1", bus.dtack_n); end
        checks++; if (bus.berr_n !== 1'b1) begin errors++; $display("FAIL reset_berr_n: got %b expected 1", bus.berr_n); end
        checks++; if (overlay !== 1'b1) begin errors++; $display("FAIL reset_overlay: got %b expected 1", overlay); end
        checks++; if (timeout_seen !== 1'b0) begin errors++; $display("FAIL reset_timeout_seen: got %b expected 0", timeout_seen); end
        checks++; if (cs !== 2'd0) begin errors++; $display("FAIL reset_cs: got %0d expected 0", cs); end
    endtask

    task automatic test_overlay_read();
        run_cycle(11'd0, 1'b1, 1'b0, 1'b0, -1, 100);
        checks++; if (obs_cs !== 2'd1) begin errors++; $display("FAIL ovl_read_cs: got %0d expected 1", obs_cs); end
        checks++; if (obs_ovl_start !== 1'b1) begin errors++; $display("FAIL ovl_read_overlay: got %b expected 1", obs_ovl_start); end
        checks++; if (obs_lat != ROM_WAIT || obs_berr) begin errors++; $display("FAIL ovl_read_latency: got %0d berr=%b expected %0d", obs_lat, obs_berr, ROM_WAIT); end
        checks++; if (obs_dtack_rel !== 1'b1) begin errors++; $display("FAIL ovl_read_dtack_release: got %b expected 1", obs_dtack_rel); end
        checks++; if (obs_oe_idle !== 1'b0) begin errors++; $display("FAIL ovl_read_idle_oe: got %b expected 0", obs_oe_idle); end
    endtask

    task automatic test_ram_write();
        run_cycle(11'd0, 1'b0, 1'b0, 1'b0, -1, 100);
        model_ovl = 1'b0;
        checks++; if (obs_cs !== 2'd2) begin errors++; $display("FAIL ram_write_cs: got %0d expected 2", obs_cs); end
        checks++; if (obs_ram_ce_n !== 1'b0) begin errors++; $display("FAIL ram_write_ce: got %b expected 0", obs_ram_ce_n); end
        checks++; if (obs_ovl_start !== 1'b0) begin errors++; $display("FAIL ram_write_overlay: got %b expected 0", obs_ovl_start); end
        checks++; if (obs_lat != RAM_WAIT || obs_berr) begin errors++; $display("FAIL ram_write_latency: got %0d expected %0d", obs_lat, RAM_WAIT); end
        run_cycle(11'd0, 1'b1, 1'b0, 1'b0, -1, 100);
        checks++; if (obs_cs !== 2'd2) begin errors++; $display("FAIL ram_read_after_clear_cs: got %0d expected 2", obs_cs); end
        checks++; if (obs_oe_n !== 1'b0) begin errors++; $display("FAIL ram_read_oe_n: got %b expected 0", obs_oe_n); end
    endtask

    task automatic test_rom_and_unmapped();
        run_cycle(11'd128, 1'b1, 1'b1, 1'b0, -1, 100);
        checks++; if (obs_cs !== 2'd1) begin errors++; $display("FAIL rom_win_cs: got %0d expected 1", obs_cs); end
        checks++; if (obs_rom_l !== 1'b0 || obs_rom_u !== 1'b1) begin errors++; $display("FAIL rom_win_strobes: got u=%b l=%b expected u=1 l=0", obs_rom_u, obs_rom_l); end
        checks++; if (obs_lat != ROM_WAIT) begin errors++; $display("FAIL rom_win_latency: got %0d expected %0d", obs_lat, ROM_WAIT); end
        run_cycle(11'd256, 1'b1, 1'b0, 1'b0, -1, 100);
        checks++; if (obs_cs !== 2'd0) begin errors++; $display("FAIL unmapped_cs: got %0d expected 0", obs_cs); end
        checks++; if (!obs_berr || obs_lat != 0) begin errors++; $display("FAIL unmapped_berr: got berr=%b lat=%0d expected berr=1 lat=0", obs_berr, obs_lat); end
        checks++; if (obs_berr_held !== 1'b1) begin errors++; $display("FAIL unmapped_berr_held: got %b expected 1", obs_berr_held); end
        checks++; if (obs_berr_idle !== 1'b1 || obs_oe_idle !== 1'b0) begin errors++; $display("FAIL unmapped_release: got berr_n=%b oe=%b expected 1 0", obs_berr_idle, obs_oe_idle); end
    endtask

    task automatic test_io();
        run_cycle(11'h780, 1'b1, 1'b0, 1'b0, 10, 200);
        checks++; if (obs_cs !== 2'd3 || obs_io_cs_n !== 1'b0) begin errors++; $display("FAIL io_decode: got cs=%0d io_cs_n=%b expected 3 0", obs_cs, obs_io_cs_n); end
        checks++; if (obs_lat != 11 || obs_berr) begin errors++; $display("FAIL io_ack_latency: got %0d berr=%b expected 11", obs_lat, obs_berr); end
        checks++; if (timeout_seen !== 1'b0) begin errors++; $display("FAIL io_ack_no_timeout: got %b expected 0", timeout_seen); end
        run_cycle(11'h780, 1'b1, 1'b0, 1'b0, -1, 200);
        checks++; if (!obs_berr || obs_lat != TO_CYCLES) begin errors++; $display("FAIL io_timeout: got berr=%b lat=%0d expected berr=1 lat=%0d", obs_berr, obs_lat, TO_CYCLES); end
        checks++; if (timeout_seen !== 1'b1) begin errors++; $display("FAIL io_timeout_seen: got %b expected 1", timeout_seen); end
    endtask

    task automatic test_boot();
        int seen;
        int lat;
        apply_reset();
        boot = 1'b1;
        bus.addr = 11'd0; bus.rw = 1'b1; bus.uds_n = 1'b0; bus.lds_n = 1'b0; bus.as_n = 1'b0;
        seen = 0;
        for (int n = 0; n < 200; n++) begin
            step();
            if (!bus.dtack_n || !bus.berr_n) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL boot_manual_hold: got %0d acknowledged edges expected 0", seen); end
        dtack_trig = 1'b1;
        lat = -1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 4) dtack_trig = 1'b0;
            if (!bus.dtack_n) begin lat = n; break; end
        end
        dtack_trig = 1'b0;
        checks++; if (lat < 2 || lat > 4) begin errors++; $display("FAIL boot_trigger_latency: got %0d expected 2..4", lat); end
        bus.uds_n = 1'b1; bus.lds_n = 1'b1; bus.as_n = 1'b1;
        step(); step(); step();
        run_cycle(11'd0, 1'b0, 1'b0, 1'b0, -1, 20);
        checks++; if (obs_cs !== 2'd1 || obs_oe_n !== 1'b1) begin errors++; $display("FAIL boot_write_decode: got cs=%0d oe_n=%b expected 1 1", obs_cs, obs_oe_n); end
        checks++; if (overlay !== 1'b1) begin errors++; $display("FAIL boot_write_overlay: got %b expected 1", overlay); end
        boot = 1'b0;
        step();
    endtask

    task automatic test_reset_midcycle();
        run_cycle(11'd0, 1'b0, 1'b0, 1'b0, -1, 100);
        checks++; if (overlay !== 1'b0) begin errors++; $display("FAIL midreset_pre_overlay: got %b expected 0", overlay); end
        bus.addr = 11'd128; bus.rw = 1'b1; bus.uds_n = 1'b0; bus.lds_n = 1'b0; bus.as_n = 1'b0;
        step(); step();
        checks++; if (bus.dtack_oe !== 1'b1 || bus.dtack_n !== 1'b1) begin errors++; $display("FAIL midreset_waiting: got oe=%b dtack_n=%b expected 1 1", bus.dtack_oe, bus.dtack_n); end
        reset_n = 1'b0;
        step();
        checks++; if (bus.dtack_oe !== 1'b0 || overlay !== 1'b1) begin errors++; $display("FAIL midreset_release: got oe=%b overlay=%b expected 0 1", bus.dtack_oe, overlay); end
        checks++; if (bus.dtack_n !== 1'b1 || bus.berr_n !== 1'b1) begin errors++; $display("FAIL midreset_outputs: got dtack_n=%b berr_n=%b expected 1 1", bus.dtack_n, bus.berr_n); end
        reset_n = 1'b1;
        idle_bus();
        model_ovl = 1'b1;
        step();
    endtask

    task automatic test_clk_out();
        logic prev;
        int found, period, high;
        found = 0; period = 0; high = 0;
        prev = clk_out;
        for (int n = 0; n < 40 && found == 0; n++) begin
            step();
            if (!prev && clk_out) found = 1;
            prev = clk_out;
        end
        for (int n = 0; n < 40 && found == 1; n++) begin
            if (clk_out) high++;
            step();
            period++;
            if (!prev && clk_out) found = 2;
            prev = clk_out;
        end
        checks++; if (found != 2 || period != 16) begin errors++; $display("FAIL clk_out_period: got %0d expected 16", period); end
        checks++; if (high != 8) begin errors++; $display("FAIL clk_out_high: got %0d expected 8", high); end
    endtask

    task automatic test_random();
        logic [10:0] ad;
        logic rd, u, l;
        logic [1:0] sel, ec;
        int d, el;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       ad = 11'($urandom_range(0, 1));
                1:       ad = 11'($urandom_range(2, 127));
                2:       ad = 11'($urandom_range(128, 129));
                3:       ad = 11'($urandom_range(1920, 2047));
                default: ad = 11'($urandom_range(130, 1919));
            endcase
            rd  = 1'($urandom_range(0, 1));
            sel = 2'($urandom_range(1, 3));
            u = ~sel[1]; l = ~sel[0];
            ec = ref_cs(ad, rd, 1'b0, model_ovl);
            d  = (ec == 2'd3) ? $urandom_range(0, 20) : -1;
            el = ref_lat(ec, d);
            run_cycle(ad, rd, u, l, d, 200);
            if (!rd && int'(ad) * 32'h2000 < ROM_SIZE) model_ovl = 1'b0;
            checks++; if (obs_cs !== ec) begin errors++; $display("FAIL rand_cs[%0d]: addr=%h got %0d expected %0d", i, ad, obs_cs, ec); end
            checks++; if (obs_lat != el || obs_berr !== (ec == 2'd0)) begin errors++; $display("FAIL rand_latency[%0d]: addr=%h got lat=%0d berr=%b expected lat=%0d berr=%b", i, ad, obs_lat, obs_berr, el, ec == 2'd0); end
            checks++; if (obs_ram_ce_n !== (ec != 2'd2) || obs_io_cs_n !== (ec != 2'd3) || obs_oe_n !== ~rd) begin errors++; $display("FAIL rand_strobes[%0d]: got ce=%b io=%b oe=%b", i, obs_ram_ce_n, obs_io_cs_n, obs_oe_n); end
            checks++; if (obs_rom_u !== ((ec == 2'd1) ? u : 1'b1) || obs_rom_l !== ((ec == 2'd1) ? l : 1'b1)) begin errors++; $display("FAIL rand_rom_strobes[%0d]: got u=%b l=%b", i, obs_rom_u, obs_rom_l); end
            checks++; if (overlay !== model_ovl || obs_oe_idle !== 1'b0) begin errors++; $display("FAIL rand_overlay_idle[%0d]: got ovl=%b oe=%b expected ovl=%b oe=0", i, overlay, obs_oe_idle, model_ovl); end
        end
    endtask

    initial begin
        test_reset();
        test_overlay_read();
        test_ram_write();
        test_rom_and_unmapped();
        test_io();
        test_boot();
        test_reset_midcycle();
        test_clk_out();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
